// File: rtl/vpu_sram_rd_responder.sv
// Bank-side completer for the VPU source read port: accepts read beats, drives the
// bank macro, returns data in order. Optional parity check: VPU_SRAM_RSP_PARITY_EN.
module vpu_sram_rd_responder #(
    parameter int BANK_ID             = 0,
    parameter int SRAM_BANK_CNT_LG2   = 3,
    parameter int SRAM_BANK_DEPTH_LG2 = 10,
    parameter int SRAM_DATA_WIDTH     = 512,
    parameter int SRAM_RD_LAT         = 4,
    parameter int MAX_OUTSTANDING     = 4,
    localparam int OUT_W              = $clog2(MAX_OUTSTANDING + 1),
`ifdef VPU_SRAM_RSP_PARITY_EN
    localparam int SRAM_W             = SRAM_DATA_WIDTH + SRAM_DATA_WIDTH / 8
`else
    localparam int SRAM_W             = SRAM_DATA_WIDTH
`endif
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           req,
    input  logic [SRAM_BANK_CNT_LG2-1:0]   rid,
    input  logic [SRAM_BANK_DEPTH_LG2-1:0] addr,
    input  logic                           reb,
    input  logic                           rlast,
    output logic                           ack,
    output logic [SRAM_DATA_WIDTH-1:0]     rdata,
    output logic                           rvalid,
`ifdef VPU_SRAM_RSP_PARITY_EN
    output logic                           rerr,
`endif
    output logic                           busy,
    output logic                           sram_ceb,
    output logic [SRAM_BANK_DEPTH_LG2-1:0] sram_addr,
    input  logic [SRAM_W-1:0]              sram_rdata,
    output logic [1:0]                     dbg_state,
    output logic [OUT_W-1:0]               dbg_outstanding
);

    // Handshake: a beat is held on req until ack pulses for one cycle; the cycle
    // after ack is never an accept, so a held req cannot be taken twice.
    // rvalid has no ready: the requester must sink every returned word.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam logic [SRAM_BANK_CNT_LG2-1:0] BANK_SEL = SRAM_BANK_CNT_LG2'(BANK_ID);
    localparam logic [OUT_W-1:0]             MAX_OUT  = OUT_W'(MAX_OUTSTANDING);

    state_t                           state_q, state_d;
    logic                             ack_q;
    logic                             rvalid_q;
    logic                             ceb_q;
    logic [SRAM_DATA_WIDTH-1:0]       rdata_q;
    logic [SRAM_BANK_DEPTH_LG2-1:0]   saddr_q;
    logic [OUT_W-1:0]                 out_q, out_d;
    logic [SRAM_RD_LAT-1:0]           pipe_q, pipe_d;
    logic                             accept;
    logic                             ret;
    logic                             rerr_q;
    logic                             par_err;

    assign ret    = pipe_q[SRAM_RD_LAT-1];
    assign accept = req && !reb && (rid == BANK_SEL) && !ack_q
                    && (out_q < MAX_OUT) && (state_q != ST_DRAIN);

    always_comb begin
        out_d = out_q;
        if (accept && !ret) begin
            out_d = out_q + OUT_W'(1);
        end else if (!accept && ret) begin
            out_d = out_q - OUT_W'(1);
        end
    end

    // Token enters with the macro's sampling edge, so it exits together with the data.
    always_comb begin
        pipe_d    = '0;
        pipe_d[0] = ~ceb_q;
        for (int i = 1; i < SRAM_RD_LAT; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept) state_d = rlast ? ST_DRAIN : ST_BURST;
            ST_BURST: if (accept && rlast) state_d = ST_DRAIN;
            ST_DRAIN: if (out_d == '0) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

`ifdef VPU_SRAM_RSP_PARITY_EN
    // Even parity: each stored parity bit equals the XOR of its data byte.
    always_comb begin
        par_err = 1'b0;
        for (int b = 0; b < SRAM_DATA_WIDTH / 8; b++) begin
            if ((^sram_rdata[b*8 +: 8]) != sram_rdata[SRAM_DATA_WIDTH + b]) begin
                par_err = 1'b1;
            end
        end
    end
`else
    assign par_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            ack_q    <= 1'b0;
            ceb_q    <= 1'b1;
            saddr_q  <= '0;
            pipe_q   <= '0;
            out_q    <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rerr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ack_q    <= accept;
            ceb_q    <= ~accept;
            if (accept) begin
                saddr_q <= addr;
            end
            pipe_q   <= pipe_d;
            out_q    <= out_d;
            rvalid_q <= ret;
            if (ret) begin
                rdata_q <= sram_rdata[SRAM_DATA_WIDTH-1:0];
                rerr_q  <= par_err;
            end
        end
    end

    assign ack             = ack_q;
    assign rvalid          = rvalid_q;
    assign rdata           = rdata_q;
    assign sram_ceb        = ceb_q;
    assign sram_addr       = saddr_q;
    assign busy            = (state_q != ST_IDLE) || (out_q != '0);
    assign dbg_state       = state_q;
    assign dbg_outstanding = out_q;
`ifdef VPU_SRAM_RSP_PARITY_EN
    assign rerr            = rerr_q;
`endif

endmodule

// File: tb/tb_vpu_sram_rd_responder.sv
// Bench for vpu_sram_rd_responder: one instance with 4 credits, one with 2,
// each fed by a pipelined macro model; scoreboards check data, order and latency.
module tb_vpu_sram_rd_responder;

  localparam int CW = 3;
  localparam int AW = 10;
  localparam int W = 512;
  localparam int LAT = 4;
`ifdef VPU_SRAM_RSP_PARITY_EN
  localparam int PW = W / 8;
  localparam int SW = W + PW;
`else
  localparam int SW = W;
`endif
  localparam logic [CW-1:0] BANK = 3'd2;
  localparam logic [AW-1:0] FLIP_ADDR = 10'h3A5;
  localparam logic [7:0] TAG_A = 8'hA5;
  localparam logic [7:0] TAG_B = 8'hB6;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  int cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

  // ---------------- DUT A (4 credits) ----------------
  logic a_req = 0, a_reb = 0, a_rlast = 0;
  logic [CW-1:0] a_rid = '0;
  logic [AW-1:0] a_addr = '0;
  logic a_ack, a_rvalid, a_busy, a_ceb, a_rerr;
  logic [W-1:0] a_rdata;
  logic [AW-1:0] a_saddr;
  logic [SW-1:0] a_srdata;
  logic [1:0] a_state;
  logic [2:0] a_out;

  vpu_sram_rd_responder #(
    .BANK_ID(2), .SRAM_BANK_CNT_LG2(CW), .SRAM_BANK_DEPTH_LG2(AW),
    .SRAM_DATA_WIDTH(W), .SRAM_RD_LAT(LAT), .MAX_OUTSTANDING(4)
  ) dut_a (
    .clk(clk), .rst(rst), .req(a_req), .rid(a_rid), .addr(a_addr), .reb(a_reb),
    .rlast(a_rlast), .ack(a_ack), .rdata(a_rdata), .rvalid(a_rvalid),
`ifdef VPU_SRAM_RSP_PARITY_EN
    .rerr(a_rerr),
`endif
    .busy(a_busy), .sram_ceb(a_ceb), .sram_addr(a_saddr), .sram_rdata(a_srdata),
    .dbg_state(a_state), .dbg_outstanding(a_out)
  );

  // ---------------- DUT B (2 credits) ----------------
  logic b_req = 0, b_reb = 0, b_rlast = 0;
  logic [CW-1:0] b_rid = '0;
  logic [AW-1:0] b_addr = '0;
  logic b_ack, b_rvalid, b_busy, b_ceb, b_rerr;
  logic [W-1:0] b_rdata;
  logic [AW-1:0] b_saddr;
  logic [SW-1:0] b_srdata;
  logic [1:0] b_state;
  logic [1:0] b_out;

  vpu_sram_rd_responder #(
    .BANK_ID(2), .SRAM_BANK_CNT_LG2(CW), .SRAM_BANK_DEPTH_LG2(AW),
    .SRAM_DATA_WIDTH(W), .SRAM_RD_LAT(LAT), .MAX_OUTSTANDING(2)
  ) dut_b (
    .clk(clk), .rst(rst), .req(b_req), .rid(b_rid), .addr(b_addr), .reb(b_reb),
    .rlast(b_rlast), .ack(b_ack), .rdata(b_rdata), .rvalid(b_rvalid),
`ifdef VPU_SRAM_RSP_PARITY_EN
    .rerr(b_rerr),
`endif
    .busy(b_busy), .sram_ceb(b_ceb), .sram_addr(b_saddr), .sram_rdata(b_srdata),
    .dbg_state(b_state), .dbg_outstanding(b_out)
  );

`ifndef VPU_SRAM_RSP_PARITY_EN
  assign a_rerr = 1'b0;
  assign b_rerr = 1'b0;
`endif

  // ---------------- macro models ----------------
  function automatic logic [W-1:0] data_of(input logic [AW-1:0] a, input logic [7:0] tag);
    logic [W-1:0] d;
    for (int i = 0; i < W / 32; i++) d[i*32 +: 32] = {tag, 8'(i), 6'd0, a};
    return d;
  endfunction

  function automatic logic [W-1:0] exp_word(input logic [AW-1:0] a, input logic [7:0] tag);
    logic [W-1:0] d;
    d = data_of(a, tag);
`ifdef VPU_SRAM_RSP_PARITY_EN
    if (a == FLIP_ADDR) d[56] = ~d[56];
`endif
    return d;
  endfunction

  function automatic logic [SW-1:0] macro_word(input logic [AW-1:0] a, input logic [7:0] tag);
`ifdef VPU_SRAM_RSP_PARITY_EN
    logic [W-1:0] clean;
    logic [PW-1:0] p;
    clean = data_of(a, tag);
    for (int b = 0; b < PW; b++) p[b] = ^clean[b*8 +: 8];
    return {p, exp_word(a, tag)};
`else
    return exp_word(a, tag);
`endif
  endfunction

  logic [SW-1:0] a_dp[LAT];
  logic [SW-1:0] b_dp[LAT];
  always @(posedge clk) begin
    a_dp[0] <= macro_word(a_saddr, TAG_A);
    b_dp[0] <= macro_word(b_saddr, TAG_B);
    for (int i = 1; i < LAT; i++) begin
      a_dp[i] <= a_dp[i-1];
      b_dp[i] <= b_dp[i-1];
    end
  end
  assign a_srdata = a_dp[LAT-1];
  assign b_srdata = b_dp[LAT-1];

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail = 0;

  task automatic check(input bit ok, input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  logic [W-1:0] a_exp_q[$];
  int a_t_q[$];
  bit a_e_q[$];
  logic [W-1:0] b_exp_q[$];
  int b_t_q[$];
  int a_ceb_cnt = 0, a_rv_cnt = 0;
  int b_max = 0;
  logic a_prev_ack = 0, a_prev_ceb = 1;
  logic [1:0] a_prev_state = 0;

  always @(negedge clk) begin
    logic [W-1:0] d;
    int t;
    bit e;
    if (!rst) begin
      if (a_ack) begin
        a_exp_q.push_back(exp_word(a_addr, TAG_A));
        a_t_q.push_back(cyc + LAT + 1);
        a_e_q.push_back(a_addr == FLIP_ADDR);
        check(a_prev_state != 2'd2, "a_ack_in_drain", W'(a_prev_state), W'(0));
        check(!a_prev_ack, "a_ack_pulse", W'(a_prev_ack), W'(0));
      end
      if (!a_ceb) begin
        a_ceb_cnt++;
        check(a_ack, "a_ceb_with_ack", W'(a_ack), W'(1));
        check(a_saddr == a_addr, "a_sram_addr", W'(a_saddr), W'(a_addr));
        check(a_prev_ceb, "a_ceb_pulse", W'(a_prev_ceb), W'(1));
      end
      if (a_rvalid) begin
        a_rv_cnt++;
        if (a_exp_q.size() == 0) begin
          check(1'b0, "a_unexpected_rvalid", W'(1), W'(0));
        end else begin
          d = a_exp_q.pop_front();
          t = a_t_q.pop_front();
          e = a_e_q.pop_front();
          check(a_rdata == d, "a_rdata", a_rdata, d);
          check(cyc == t, "a_rvalid_cycle", W'(cyc), W'(t));
`ifdef VPU_SRAM_RSP_PARITY_EN
          check(a_rerr == e, "a_rerr", W'(a_rerr), W'(e));
`endif
        end
      end
      if (b_ack) begin
        b_exp_q.push_back(exp_word(b_addr, TAG_B));
        b_t_q.push_back(cyc + LAT + 1);
      end
      if (b_rvalid) begin
        if (b_exp_q.size() == 0) begin
          check(1'b0, "b_unexpected_rvalid", W'(1), W'(0));
        end else begin
          d = b_exp_q.pop_front();
          t = b_t_q.pop_front();
          check(b_rdata == d, "b_rdata", b_rdata, d);
          check(cyc == t, "b_rvalid_cycle", W'(cyc), W'(t));
        end
      end
      if (int'(b_out) > b_max) b_max = int'(b_out);
    end
    a_prev_ack = a_ack;
    a_prev_ceb = a_ceb;
    a_prev_state = a_state;
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input bit sel, input logic [CW-1:0] rid, input logic [AW-1:0] addr,
                       input logic reb, input logic rlast);
    if (sel) begin
      b_req = 1; b_rid = rid; b_addr = addr; b_reb = reb; b_rlast = rlast;
    end else begin
      a_req = 1; a_rid = rid; a_addr = addr; a_reb = reb; a_rlast = rlast;
    end
  endtask

  task automatic idle(input bit sel);
    if (sel) b_req = 0;
    else a_req = 0;
  endtask

  task automatic wait_ack(input bit sel, input int lim, output int c);
    c = -1;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (sel ? b_ack : a_ack) begin
        c = cyc;
        break;
      end
    end
    #1;
  endtask

  int ack_c[8];
  task automatic burst(input bit sel, input logic [AW-1:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      drive(sel, BANK, base + AW'(i), 1'b0, i == n - 1);
      wait_ack(sel, 30, ack_c[i]);
      check(ack_c[i] >= 0, "burst_ack_seen", W'(ack_c[i]), W'(1));
    end
  endtask

  // ---------------- stimulus ----------------
  typedef struct {
    logic [CW-1:0] rid;
    logic reb;
    logic [AW-1:0] addr;
    bit exp_ack;
  } vec_t;
  vec_t vecs[7];

  initial begin
    int c, c0, ceb0, rv0;
    vecs[0] = '{BANK,      1'b0, 10'h010, 1'b1};
    vecs[1] = '{BANK + 1,  1'b0, 10'h011, 1'b0};
    vecs[2] = '{BANK,      1'b1, 10'h012, 1'b0};
    vecs[3] = '{3'd0,      1'b0, 10'h013, 1'b0};
    vecs[4] = '{BANK,      1'b0, 10'h3FF, 1'b1};
    vecs[5] = '{BANK,      1'b0, FLIP_ADDR, 1'b1};
    vecs[6] = '{BANK,      1'b0, 10'h000, 1'b1};

    repeat (3) @(negedge clk);
    #1;
    check(a_ack == 0, "rst_ack", W'(a_ack), W'(0));
    check(a_rvalid == 0, "rst_rvalid", W'(a_rvalid), W'(0));
    check(a_rdata == '0, "rst_rdata", a_rdata, W'(0));
    check(a_ceb == 1, "rst_ceb", W'(a_ceb), W'(1));
    check(a_saddr == '0, "rst_sram_addr", W'(a_saddr), W'(0));
    check(a_busy == 0, "rst_busy", W'(a_busy), W'(0));
    check(a_state == 0, "rst_state", W'(a_state), W'(0));
    check(a_out == 0, "rst_outstanding", W'(a_out), W'(0));
    rst = 0;
    @(negedge clk);
    #1;

    // single beats and filtering, one table record at a time
    for (int i = 0; i < 7; i++) begin
      c0 = cyc; ceb0 = a_ceb_cnt; rv0 = a_rv_cnt;
      drive(0, vecs[i].rid, vecs[i].addr, vecs[i].reb, 1'b1);
      wait_ack(0, 6, c);
      check((c >= 0) == vecs[i].exp_ack, "tbl_ack", W'(c >= 0), W'(vecs[i].exp_ack));
      if (vecs[i].exp_ack) begin
        check(c == c0 + 1, "tbl_ack_cycle", W'(c), W'(c0 + 1));
        check(a_state == 2'd2, "tbl_state_drain", W'(a_state), W'(2));
        check(a_busy == 1, "tbl_busy_high", W'(a_busy), W'(1));
      end
      idle(0);
      repeat (14) @(negedge clk);
      #1;
      check(a_state == 2'd0, "tbl_state_idle", W'(a_state), W'(0));
      check(a_busy == 0, "tbl_busy_low", W'(a_busy), W'(0));
      check(a_ceb_cnt - ceb0 == int'(vecs[i].exp_ack), "tbl_ceb_count", W'(a_ceb_cnt - ceb0), W'(vecs[i].exp_ack));
      check(a_rv_cnt - rv0 == int'(vecs[i].exp_ack), "tbl_rvalid_count", W'(a_rv_cnt - rv0), W'(vecs[i].exp_ack));
    end

    // 4-beat burst with req held, then a 5th beat held through the drain
    burst(0, 10'h000, 4);
    for (int i = 1; i < 4; i++)
      check(ack_c[i] - ack_c[i-1] == 2, "burst_ack_gap", W'(ack_c[i] - ack_c[i-1]), W'(2));
    drive(0, BANK, 10'h004, 1'b0, 1'b1);
    wait_ack(0, 30, c);
    check(c == ack_c[3] + 6, "burst_5th_after_drain", W'(c), W'(ack_c[3] + 6));
    idle(0);
    repeat (14) @(negedge clk);
    #1;
    check(a_exp_q.size() == 0, "burst_all_returned", W'(a_exp_q.size()), W'(0));

    // credit limit on the 2-credit instance
    burst(1, 10'h040, 4);
    idle(1);
    check(ack_c[1] - ack_c[0] == 2, "credit_gap1", W'(ack_c[1] - ack_c[0]), W'(2));
    check(ack_c[2] - ack_c[1] == 4, "credit_gap2", W'(ack_c[2] - ack_c[1]), W'(4));
    check(ack_c[3] - ack_c[2] == 2, "credit_gap3", W'(ack_c[3] - ack_c[2]), W'(2));
    repeat (14) @(negedge clk);
    #1;
    check(b_max == 2, "credit_max_outstanding", W'(b_max), W'(2));
    check(b_exp_q.size() == 0, "credit_all_returned", W'(b_exp_q.size()), W'(0));
    check(b_busy == 0, "credit_busy_low", W'(b_busy), W'(0));

    // reset in the middle of a burst
    drive(0, BANK, 10'h020, 1'b0, 1'b0);
    wait_ack(0, 6, c);
    drive(0, BANK, 10'h021, 1'b0, 1'b0);
    wait_ack(0, 6, c);
    drive(0, BANK, 10'h022, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    #1;
    rst = 1;
    a_req = 0;
    #1;
    a_exp_q.delete(); a_t_q.delete(); a_e_q.delete();
    check(a_ack == 0, "mid_rst_ack", W'(a_ack), W'(0));
    check(a_rvalid == 0, "mid_rst_rvalid", W'(a_rvalid), W'(0));
    check(a_rdata == '0, "mid_rst_rdata", a_rdata, W'(0));
    check(a_ceb == 1, "mid_rst_ceb", W'(a_ceb), W'(1));
    check(a_busy == 0, "mid_rst_busy", W'(a_busy), W'(0));
    check(a_out == 0, "mid_rst_outstanding", W'(a_out), W'(0));
    repeat (3) @(negedge clk);
    #1;
    rst = 0;
    rv0 = a_rv_cnt;
    repeat (20) @(negedge clk);
    #1;
    check(a_rv_cnt == rv0, "post_rst_no_rvalid", W'(a_rv_cnt - rv0), W'(0));
    drive(0, BANK, 10'h030, 1'b0, 1'b1);
    wait_ack(0, 6, c);
    check(c >= 0, "post_rst_ack", W'(c >= 0), W'(1));
    idle(0);
    repeat (14) @(negedge clk);
    #1;
    check(a_rv_cnt == rv0 + 1, "post_rst_rvalid", W'(a_rv_cnt - rv0), W'(1));
    check(a_exp_q.size() == 0, "final_a_queue_empty", W'(a_exp_q.size()), W'(0));
    check(a_busy == 0, "final_busy_low", W'(a_busy), W'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
